id_stage: RTL and testbench

- Instruction-decode stage of the 5-stage ARM pipeline.
- Drives the register-file read addresses and decodes the fetched instruction into execute controls.
- Evaluates the ARM condition field against the status flags.
- Captures everything into the ID/EX pipeline register on posedge clk, consumed by the EX stage next cycle.

---
 rtl/arm_defs.sv | 90 +++++++++
 rtl/id_stage_if.sv | 47 ++++
 rtl/id_control_unit.sv | 54 +++++
 rtl/id_stage.sv | 110 +++++++++++
 tb/tb_id_stage.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/arm_defs.sv
// Shared encodings for the ARM decode stage: instruction modes, data-processing
// opcodes, ALU commands, condition codes, status-flag positions and the
// control bundle handed from decode to execute.
package arm_defs;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_MVN = 4'b1111;

  localparam logic [3:0] EXE_NOP = 4'b0000;
  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;
  localparam logic [3:0] EXE_MVN = 4'b1001;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  typedef struct packed {
    logic [3:0] exe_cmd;
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       b;
    logic       s;
  } ctrl_t;

  // Evaluates a condition field against NZCV; 1111 (never) falls to default.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] status);
    logic n, z, c, v;
    n = status[N_BIT];
    z = status[Z_BIT];
    c = status[C_BIT];
    v = status[V_BIT];
    case (cond)
      COND_EQ: cond_pass = z;
      COND_NE: cond_pass = ~z;
      COND_CS: cond_pass = c;
      COND_CC: cond_pass = ~c;
      COND_MI: cond_pass = n;
      COND_PL: cond_pass = ~n;
      COND_VS: cond_pass = v;
      COND_VC: cond_pass = ~v;
      COND_HI: cond_pass = c & ~z;
      COND_LS: cond_pass = ~c | z;
      COND_GE: cond_pass = (n == v);
      COND_LT: cond_pass = (n != v);
      COND_GT: cond_pass = ~z & (n == v);
      COND_LE: cond_pass = z | (n != v);
      COND_AL: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// IF/ID-side inputs and ID/EX-side outputs of the decode stage. The decode
// stage is the slave; whatever drives fetch data and consumes ID/EX is master.
interface id_stage_if #(
  parameter int WIDTH = 32,
  parameter int RADDR = 4
);
  logic             flush;
  logic             hazard;
  logic [WIDTH-1:0] pc_in;
  logic [31:0]      instruction;
  logic [3:0]       status;
  logic [WIDTH-1:0] reg_1;
  logic [WIDTH-1:0] reg_2;

  logic [RADDR-1:0] src_1;
  logic [RADDR-1:0] src_2;
  logic             two_src;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] val_rn;
  logic [WIDTH-1:0] val_rm;
  logic             imm;
  logic [11:0]      shift_operand;
  logic [23:0]      signed_imm_24;
  logic [RADDR-1:0] dest;
  logic [RADDR-1:0] src_1_out;
  logic [RADDR-1:0] src_2_out;
  logic [3:0]       exe_cmd;
  logic             wb_en;
  logic             mem_r_en;
  logic             mem_w_en;
  logic             b;
  logic             s;

  modport slave (
    input  flush, hazard, pc_in, instruction, status, reg_1, reg_2,
    output src_1, src_2, two_src, pc_out, val_rn, val_rm, imm, shift_operand,
           signed_imm_24, dest, src_1_out, src_2_out, exe_cmd, wb_en,
           mem_r_en, mem_w_en, b, s
  );

  modport master (
    output flush, hazard, pc_in, instruction, status, reg_1, reg_2,
    input  src_1, src_2, two_src, pc_out, val_rn, val_rm, imm, shift_operand,
           signed_imm_24, dest, src_1_out, src_2_out, exe_cmd, wb_en,
           mem_r_en, mem_w_en, b, s
  );
endinterface

// File: rtl/id_control_unit.sv
// Combinational main decoder: instruction mode, opcode and S bit to the ALU
// command and pipeline control bits. Condition/hazard gating happens upstream.
module id_control_unit
  import arm_defs::*;
(
  input  logic [1:0] mode,
  input  logic [3:0] opcode,
  input  logic       s_bit,
  output ctrl_t      ctrl
);

  // Decode mode/opcode; anything unrecognised leaves every control at 0.
  always_comb begin
    ctrl = '0;
    case (mode)
      MODE_DP: begin
        ctrl.wb_en = 1'b1;
        ctrl.s     = s_bit;
        case (opcode)
          OP_MOV: ctrl.exe_cmd = EXE_MOV;
          OP_MVN: ctrl.exe_cmd = EXE_MVN;
          OP_ADD: ctrl.exe_cmd = EXE_ADD;
          OP_ADC: ctrl.exe_cmd = EXE_ADC;
          OP_SUB: ctrl.exe_cmd = EXE_SUB;
          OP_SBC: ctrl.exe_cmd = EXE_SBC;
          OP_AND: ctrl.exe_cmd = EXE_AND;
          OP_ORR: ctrl.exe_cmd = EXE_ORR;
          OP_EOR: ctrl.exe_cmd = EXE_EOR;
          OP_CMP: begin
            ctrl.exe_cmd = EXE_SUB;
            ctrl.wb_en   = 1'b0;
          end
          OP_TST: begin
            ctrl.exe_cmd = EXE_AND;
            ctrl.wb_en   = 1'b0;
          end
          default: ctrl = '0;
        endcase
      end
      MODE_MEM: begin
        ctrl.exe_cmd = EXE_ADD;
        if (s_bit) begin
          ctrl.mem_r_en = 1'b1;
          ctrl.wb_en    = 1'b1;
        end else begin
          ctrl.mem_w_en = 1'b1;
        end
      end
      MODE_BR: ctrl.b = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// ARM pipeline instruction-decode stage: register-file read addressing,
// condition evaluation, control decode and the ID/EX pipeline register.
module id_stage
  import arm_defs::*;
#(
  parameter int WIDTH = 32,
  parameter int RADDR = 4
) (
  input logic       clk,
  input logic       rst,
  id_stage_if.slave bus
);

  logic [3:0]       cond;
  logic [1:0]       mode;
  logic             i_bit;
  logic [3:0]       opcode;
  logic             s_bit;
  logic [RADDR-1:0] rn, rd, rm;
  logic             is_str;
  logic             cond_ok;
  ctrl_t            ctrl, ctrl_eff;

  logic [WIDTH-1:0] pc_q, rn_q, rm_q;
  logic             imm_q;
  logic [11:0]      shift_q;
  logic [23:0]      simm_q;
  logic [RADDR-1:0] dest_q, src_1_q, src_2_q;
  ctrl_t            ctrl_q;

  assign cond   = bus.instruction[31:28];
  assign mode   = bus.instruction[27:26];
  assign i_bit  = bus.instruction[25];
  assign opcode = bus.instruction[24:21];
  assign s_bit  = bus.instruction[20];
  assign rn     = bus.instruction[16 +: RADDR];
  assign rd     = bus.instruction[12 +: RADDR];
  assign rm     = bus.instruction[0 +: RADDR];

  // A store reads its data register through the second read port.
  assign is_str      = (mode == MODE_MEM) & ~s_bit;
  assign bus.src_1   = rn;
  assign bus.src_2   = is_str ? rd : rm;
  assign bus.two_src = ((mode == MODE_DP) & ~i_bit) | is_str;

  id_control_unit u_ctrl (
    .mode   (mode),
    .opcode (opcode),
    .s_bit  (s_bit),
    .ctrl   (ctrl)
  );

  assign cond_ok  = cond_pass(cond, bus.status);
  assign ctrl_eff = (cond_ok && !bus.hazard) ? ctrl : '0;

  // ID/EX register: async clear, flush clears, otherwise capture; a bubble only zeroes controls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      imm_q   <= 1'b0;
      shift_q <= '0;
      simm_q  <= '0;
      dest_q  <= '0;
      src_1_q <= '0;
      src_2_q <= '0;
      ctrl_q  <= '0;
    end else if (bus.flush) begin
      pc_q    <= '0;
      rn_q    <= '0;
      rm_q    <= '0;
      imm_q   <= 1'b0;
      shift_q <= '0;
      simm_q  <= '0;
      dest_q  <= '0;
      src_1_q <= '0;
      src_2_q <= '0;
      ctrl_q  <= '0;
    end else begin
      pc_q    <= bus.pc_in;
      rn_q    <= bus.reg_1;
      rm_q    <= bus.reg_2;
      imm_q   <= i_bit;
      shift_q <= bus.instruction[11:0];
      simm_q  <= bus.instruction[23:0];
      dest_q  <= rd;
      src_1_q <= bus.src_1;
      src_2_q <= bus.src_2;
      ctrl_q  <= ctrl_eff;
    end
  end

  assign bus.pc_out        = pc_q;
  assign bus.val_rn        = rn_q;
  assign bus.val_rm        = rm_q;
  assign bus.imm           = imm_q;
  assign bus.shift_operand = shift_q;
  assign bus.signed_imm_24 = simm_q;
  assign bus.dest          = dest_q;
  assign bus.src_1_out     = src_1_q;
  assign bus.src_2_out     = src_2_q;
  assign bus.exe_cmd       = ctrl_q.exe_cmd;
  assign bus.wb_en         = ctrl_q.wb_en;
  assign bus.mem_r_en      = ctrl_q.mem_r_en;
  assign bus.mem_w_en      = ctrl_q.mem_w_en;
  assign bus.b             = ctrl_q.b;
  assign bus.s             = ctrl_q.s;

endmodule

// File: tb/tb_id_stage.sv
// Bench for the decode stage: a vector table with hand-derived decode results,
// a queue of expected ID/EX contents, and short sequences for hazard, flush
// and asynchronous reset.
module tb_id_stage;

  logic clk;
  logic rst;

  id_stage_if #(.WIDTH(32), .RADDR(4)) bus_if ();

  id_stage #(.WIDTH(32), .RADDR(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [31:0] instr;
    logic [3:0]  status;
    logic        hazard;
    logic [3:0]  e_src1;
    logic [3:0]  e_src2;
    logic        e_two;
    logic [3:0]  e_exe;
    logic [4:0]  e_ctl;   // {wb_en, mem_r_en, mem_w_en, b, s}
  } vec_t;

  typedef struct {
    string      name;
    logic [31:0] pc;
    logic [31:0] rn;
    logic [31:0] rm;
    logic        imm;
    logic [11:0] shift;
    logic [23:0] simm;
    logic [3:0]  dest;
    logic [3:0]  s1;
    logic [3:0]  s2;
    logic [3:0]  exe;
    logic [4:0]  ctl;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input string n, input logic [31:0] ins, input logic [3:0] st,
                              input logic hz, input logic [3:0] s1, input logic [3:0] s2,
                              input logic two, input logic [3:0] exe, input logic [4:0] ctl);
    vec_t v;
    v.name = n; v.instr = ins; v.status = st; v.hazard = hz;
    v.e_src1 = s1; v.e_src2 = s2; v.e_two = two; v.e_exe = exe; v.e_ctl = ctl;
    return v;
  endfunction

  function automatic exp_t zero_exp(input string n);
    exp_t e;
    e.name = n; e.pc = '0; e.rn = '0; e.rm = '0; e.imm = 1'b0; e.shift = '0;
    e.simm = '0; e.dest = '0; e.s1 = '0; e.s2 = '0; e.exe = '0; e.ctl = '0;
    return e;
  endfunction

  function automatic exp_t cap_exp(input string n, input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2,
                                   input logic [3:0] s1, input logic [3:0] s2,
                                   input logic [3:0] exe, input logic [4:0] ctl);
    exp_t e;
    e.name = n; e.pc = pc; e.rn = r1; e.rm = r2; e.imm = ins[25];
    e.shift = ins[11:0]; e.simm = ins[23:0]; e.dest = ins[15:12];
    e.s1 = s1; e.s2 = s2; e.exe = exe; e.ctl = ctl;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_out(input exp_t e);
    chk({e.name, ".pc_out"}, bus_if.pc_out, e.pc);
    chk({e.name, ".val_rn"}, bus_if.val_rn, e.rn);
    chk({e.name, ".val_rm"}, bus_if.val_rm, e.rm);
    chk({e.name, ".imm"}, {31'd0, bus_if.imm}, {31'd0, e.imm});
    chk({e.name, ".shift_operand"}, {20'd0, bus_if.shift_operand}, {20'd0, e.shift});
    chk({e.name, ".signed_imm_24"}, {8'd0, bus_if.signed_imm_24}, {8'd0, e.simm});
    chk({e.name, ".dest"}, {28'd0, bus_if.dest}, {28'd0, e.dest});
    chk({e.name, ".src_1_out"}, {28'd0, bus_if.src_1_out}, {28'd0, e.s1});
    chk({e.name, ".src_2_out"}, {28'd0, bus_if.src_2_out}, {28'd0, e.s2});
    chk({e.name, ".exe_cmd"}, {28'd0, bus_if.exe_cmd}, {28'd0, e.exe});
    chk({e.name, ".ctl"},
        {27'd0, bus_if.wb_en, bus_if.mem_r_en, bus_if.mem_w_en, bus_if.b, bus_if.s},
        {27'd0, e.ctl});
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = sb.pop_front();
      check_out(e);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [3:0] st, input logic hz,
                       input logic fl, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] pc);
    bus_if.instruction = ins;
    bus_if.status      = st;
    bus_if.hazard      = hz;
    bus_if.flush       = fl;
    bus_if.reg_1       = r1;
    bus_if.reg_2       = r2;
    bus_if.pc_in       = pc;
  endtask

  initial begin
    logic [31:0] r1, r2, pc;

    vecs.push_back(mk("add",  32'hE0810002, 4'b0000, 0, 4'd1, 4'd2,  1, 4'b0010, 5'b10000));
    vecs.push_back(mk("mov",  32'hE3A00014, 4'b0000, 0, 4'd0, 4'd4,  0, 4'b0001, 5'b10000));
    vecs.push_back(mk("str",  32'hE5801004, 4'b0000, 0, 4'd0, 4'd1,  1, 4'b0010, 5'b00100));
    vecs.push_back(mk("ldr",  32'hE5901004, 4'b0000, 0, 4'd0, 4'd4,  0, 4'b0010, 5'b11000));
    vecs.push_back(mk("beq_nt", 32'h0A000002, 4'b0000, 0, 4'd0, 4'd2, 0, 4'b0000, 5'b00000));
    vecs.push_back(mk("beq_t",  32'h0A000002, 4'b0100, 0, 4'd0, 4'd2, 0, 4'b0000, 5'b00010));
    vecs.push_back(mk("subs", 32'hE0543005, 4'b0000, 0, 4'd4, 4'd5,  1, 4'b0100, 5'b10001));
    vecs.push_back(mk("cmp",  32'hE1510002, 4'b0000, 0, 4'd1, 4'd2,  1, 4'b0100, 5'b00001));
    vecs.push_back(mk("tst",  32'hE1110002, 4'b0000, 0, 4'd1, 4'd2,  1, 4'b0110, 5'b00001));
    vecs.push_back(mk("rsb_undef", 32'hE0610002, 4'b0000, 0, 4'd1, 4'd2, 1, 4'b0000, 5'b00000));
    vecs.push_back(mk("mvn",  32'hE3E000FF, 4'b0000, 0, 4'd0, 4'd15, 0, 4'b1001, 5'b10000));
    vecs.push_back(mk("mode11", 32'hEC000000, 4'b0000, 0, 4'd0, 4'd0, 0, 4'b0000, 5'b00000));
    vecs.push_back(mk("cond_nv", 32'hF0810002, 4'b0000, 0, 4'd1, 4'd2, 1, 4'b0000, 5'b00000));
    vecs.push_back(mk("adc",  32'hE0A10002, 4'b0000, 0, 4'd1, 4'd2,  1, 4'b0011, 5'b10000));
    vecs.push_back(mk("sbc",  32'hE0C10002, 4'b0000, 0, 4'd1, 4'd2,  1, 4'b0101, 5'b10000));
    vecs.push_back(mk("and",  32'hE0010002, 4'b0000, 0, 4'd1, 4'd2,  1, 4'b0110, 5'b10000));
    vecs.push_back(mk("orr",  32'hE1810002, 4'b0000, 0, 4'd1, 4'd2,  1, 4'b0111, 5'b10000));
    vecs.push_back(mk("eor",  32'hE0210002, 4'b0000, 0, 4'd1, 4'd2,  1, 4'b1000, 5'b10000));
    vecs.push_back(mk("ge_t", 32'hA0810002, 4'b1001, 0, 4'd1, 4'd2,  1, 4'b0010, 5'b10000));
    vecs.push_back(mk("lt_t", 32'hB0810002, 4'b1000, 0, 4'd1, 4'd2,  1, 4'b0010, 5'b10000));
    vecs.push_back(mk("gt_f", 32'hC0810002, 4'b0100, 0, 4'd1, 4'd2,  1, 4'b0000, 5'b00000));
    vecs.push_back(mk("hi_t", 32'h80810002, 4'b0010, 0, 4'd1, 4'd2,  1, 4'b0010, 5'b10000));
    vecs.push_back(mk("ls_f", 32'h90810002, 4'b0010, 0, 4'd1, 4'd2,  1, 4'b0000, 5'b00000));
    vecs.push_back(mk("ne_t", 32'h10810002, 4'b0000, 0, 4'd1, 4'd2,  1, 4'b0010, 5'b10000));
    vecs.push_back(mk("mi_f", 32'h40810002, 4'b0000, 0, 4'd1, 4'd2,  1, 4'b0000, 5'b00000));
    vecs.push_back(mk("vs_t", 32'h60810002, 4'b0001, 0, 4'd1, 4'd2,  1, 4'b0010, 5'b10000));
    vecs.push_back(mk("cc_f", 32'h30810002, 4'b0010, 0, 4'd1, 4'd2,  1, 4'b0000, 5'b00000));
    vecs.push_back(mk("pl_f", 32'h50810002, 4'b1000, 0, 4'd1, 4'd2,  1, 4'b0000, 5'b00000));
    vecs.push_back(mk("vc_t", 32'h70810002, 4'b0000, 0, 4'd1, 4'd2,  1, 4'b0010, 5'b10000));
    vecs.push_back(mk("cs_t", 32'h20810002, 4'b0010, 0, 4'd1, 4'd2,  1, 4'b0010, 5'b10000));
    vecs.push_back(mk("le_t", 32'hD0810002, 4'b1000, 0, 4'd1, 4'd2,  1, 4'b0010, 5'b10000));
    vecs.push_back(mk("add_hazard", 32'hE0810002, 4'b0000, 1, 4'd1, 4'd2, 1, 4'b0000, 5'b00000));

    // Reset state before any clock edge.
    rst = 1'b1;
    drive(32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    check_out(zero_exp("reset"));
    @(negedge clk);
    rst = 1'b0;

    // Table of single instructions.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      r1 = $urandom;
      r2 = $urandom;
      pc = 32'h0000_1000 + 32'(i) * 4;
      drive(vecs[i].instr, vecs[i].status, vecs[i].hazard, 1'b0, r1, r2, pc);
      #1;
      chk({vecs[i].name, ".src_1"}, {28'd0, bus_if.src_1}, {28'd0, vecs[i].e_src1});
      chk({vecs[i].name, ".src_2"}, {28'd0, bus_if.src_2}, {28'd0, vecs[i].e_src2});
      chk({vecs[i].name, ".two_src"}, {31'd0, bus_if.two_src}, {31'd0, vecs[i].e_two});
      sb.push_back(cap_exp(vecs[i].name, vecs[i].instr, pc, r1, r2,
                           vecs[i].e_src1, vecs[i].e_src2, vecs[i].e_exe, vecs[i].e_ctl));
      @(posedge clk);
      #1;
      pop_check();
    end

    // Hazard bubble keeps data, then flush clears everything.
    @(negedge clk);
    drive(32'hE0810002, 4'b0000, 1'b1, 1'b0, 32'd5, 32'd7, 32'h2000);
    sb.push_back(cap_exp("seq_hazard", 32'hE0810002, 32'h2000, 32'd5, 32'd7,
                         4'd1, 4'd2, 4'b0000, 5'b00000));
    @(posedge clk);
    #1;
    pop_check();
    @(negedge clk);
    drive(32'hE0810002, 4'b0000, 1'b0, 1'b1, 32'd5, 32'd7, 32'h2004);
    sb.push_back(zero_exp("seq_flush"));
    @(posedge clk);
    #1;
    pop_check();

    // Valid instruction captured, then flush together with hazard.
    @(negedge clk);
    drive(32'hE0810002, 4'b0000, 1'b0, 1'b0, 32'd5, 32'd7, 32'h2008);
    sb.push_back(cap_exp("seq_pre_flush", 32'hE0810002, 32'h2008, 32'd5, 32'd7,
                         4'd1, 4'd2, 4'b0010, 5'b10000));
    @(posedge clk);
    #1;
    pop_check();
    @(negedge clk);
    drive(32'hE0810002, 4'b0000, 1'b1, 1'b1, 32'd5, 32'd7, 32'h200C);
    sb.push_back(zero_exp("seq_flush_hazard"));
    @(posedge clk);
    #1;
    pop_check();

    // Asynchronous reset between edges while wb_en is set.
    @(negedge clk);
    drive(32'hE0810002, 4'b0000, 1'b0, 1'b0, 32'd9, 32'd11, 32'h3000);
    sb.push_back(cap_exp("seq_pre_rst", 32'hE0810002, 32'h3000, 32'd9, 32'd11,
                         4'd1, 4'd2, 4'b0010, 5'b10000));
    @(posedge clk);
    #1;
    pop_check();
    #2;
    rst = 1'b1;
    #1;
    check_out(zero_exp("seq_async_rst"));
    @(posedge clk);
    #1;
    check_out(zero_exp("seq_rst_held"));
    @(negedge clk);
    rst = 1'b0;
    drive(32'hE0810002, 4'b0000, 1'b0, 1'b0, 32'd13, 32'd17, 32'h3004);
    sb.push_back(cap_exp("seq_post_rst", 32'hE0810002, 32'h3004, 32'd13, 32'd17,
                         4'd1, 4'd2, 4'b0010, 5'b10000));
    @(posedge clk);
    #1;
    pop_check();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
